// File: rtl/cic_ctrl_pkg.sv
// Shared types and constants for the CIC conversion controller.
package cic_ctrl_pkg;

   localparam int unsigned CIC_DATA_W     = 25;
   localparam int unsigned SETTLE_OUTPUTS = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_SETTLE,
      ST_RUN,
      ST_DONE
   } cic_state_t;

   function automatic logic [8:0] dec_ratio(input logic [1:0] sel);
      case (sel)
         2'b00:   return 9'd8;
         2'b01:   return 9'd64;
         default: return 9'd256;
      endcase
   endfunction

endpackage

// File: rtl/cic_out_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module cic_out_fifo #(
   parameter int unsigned DATA_W = 25,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q;
   logic              do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/cic_conv_ctrl.sv
// Conversion controller for the CIC decimator: run FSM, decimation strobe,
// settling-output discard and output FIFO with sticky overflow.
module cic_conv_ctrl
   import cic_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W     = CIC_DATA_W,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic [1:0]        dec_sel,
   input  logic [CNT_W-1:0]  num_conv,
   input  logic [DATA_W-1:0] cic_data,
   output logic              cic_clr,
   output logic              cic_en,
   output logic              dec_strobe,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   input  logic              clr_ovf
);

   cic_state_t        state_q, state_d;
   logic [7:0]        dec_last_q, dec_last_d;
   logic [7:0]        dec_cnt_q, dec_cnt_d;
   logic [CNT_W-1:0]  num_conv_q, num_conv_d;
   logic [CNT_W-1:0]  conv_cnt_q, conv_cnt_d, conv_inc;
   logic [1:0]        settle_cnt_q, settle_cnt_d;
   logic              cap_pend_q, cap_pend_d;
   logic              overflow_q, overflow_d;
   logic              counting, push, pop, drop, fifo_full, fifo_empty;

   assign counting   = (state_q == ST_SETTLE) || (state_q == ST_RUN);
   assign cic_en     = counting;
   assign dec_strobe = counting && (dec_cnt_q == dec_last_q);
   assign busy       = (state_q != ST_IDLE);
   assign conv_inc   = (&conv_cnt_q) ? conv_cnt_q : conv_cnt_q + CNT_W'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         dec_last_q   <= '0;
         dec_cnt_q    <= '0;
         num_conv_q   <= '0;
         conv_cnt_q   <= '0;
         settle_cnt_q <= '0;
         cap_pend_q   <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         dec_last_q   <= dec_last_d;
         dec_cnt_q    <= dec_cnt_d;
         num_conv_q   <= num_conv_d;
         conv_cnt_q   <= conv_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         cap_pend_q   <= cap_pend_d;
         overflow_q   <= overflow_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      dec_last_d   = dec_last_q;
      dec_cnt_d    = dec_cnt_q;
      num_conv_d   = num_conv_q;
      conv_cnt_d   = conv_cnt_q;
      settle_cnt_d = settle_cnt_q;
      cap_pend_d   = dec_strobe;
      cic_clr      = 1'b0;
      done         = 1'b0;
      push         = 1'b0;

      if (counting) begin
         dec_cnt_d = dec_strobe ? '0 : dec_cnt_q + 8'd1;
      end

      // The CIC word is valid one cycle after the strobe, so captures act on cap_pend_q.
      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d      = ST_CLEAR;
               dec_last_d   = 8'(dec_ratio(dec_sel) - 9'd1);
               num_conv_d   = num_conv;
               dec_cnt_d    = '0;
               conv_cnt_d   = '0;
               settle_cnt_d = '0;
            end
         end
         ST_CLEAR: begin
            cic_clr = 1'b1;
            state_d = stop ? ST_IDLE : ST_SETTLE;
         end
         ST_SETTLE: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (cap_pend_q) begin
               settle_cnt_d = settle_cnt_q + 2'd1;
               if (settle_cnt_q == 2'(SETTLE_OUTPUTS - 1)) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (cap_pend_q) begin
               push       = 1'b1;
               conv_cnt_d = conv_inc;
               if (num_conv_q != '0 && conv_inc == num_conv_q) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign out_valid  = !fifo_empty;
   assign pop        = out_valid && out_ready;
   assign drop       = push && fifo_full && !pop;
   assign overflow_d = drop || (overflow_q && !clr_ovf);
   assign overflow   = overflow_q;

   cic_out_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (cic_data),
      .rdata_o (out_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_cic_conv_ctrl.sv
// Randomized bench for cic_conv_ctrl: expected outputs come from closed-form run timing
// (start cycle, ratio, count, stop cycle) and a queue model of the output FIFO.
module tb_cic_conv_ctrl;

   localparam int unsigned DATA_W     = 25;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned CNT_W      = 16;
   localparam longint      INF        = 64'h3FFF_FFFF_FFFF_FFFF;

   logic              clk, reset_n, start, stop, out_ready, clr_ovf;
   logic              cic_clr, cic_en, dec_strobe, out_valid, busy, done, overflow;
   logic [1:0]        dec_sel;
   logic [CNT_W-1:0]  num_conv;
   logic [DATA_W-1:0] cic_data, out_data;

   int     n_checks = 0;
   int     n_errors = 0;
   longint cyc = 0;

   // Current run: start cycle, ratio, requested count, stop cycle.
   bit     r_on = 1'b0;
   longint r_t = 0, r_D = 8, r_n = 0, r_stop = INF;

   int                rdy_mode = 1;
   bit                clr_rand = 1'b0;
   logic [63:0]       salt;
   logic [DATA_W-1:0] mq[$];
   bit                ovf_m = 1'b0;
   bit                pushed_m = 1'b0;

   cic_conv_ctrl #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .stop       (stop),
      .dec_sel    (dec_sel),
      .num_conv   (num_conv),
      .cic_data   (cic_data),
      .cic_clr    (cic_clr),
      .cic_en     (cic_en),
      .dec_strobe (dec_strobe),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [DATA_W-1:0] data_of(input longint c);
      logic [63:0] x;
      x = 64'(c) * 64'd2654435761 + salt;
      x = x ^ (x >> 29);
      return x[DATA_W-1:0];
   endfunction

   function automatic longint last_push();
      return (r_n == 0) ? INF : r_t + 2 + (3 + r_n) * r_D;
   endfunction

   function automatic longint busy_end();
      longint p;
      p = last_push();
      if (r_stop <= p) return r_stop;
      return (p == INF) ? INF : p + 1;
   endfunction

   function automatic bit exp_busy(input longint c);
      return r_on && c >= r_t + 1 && c <= busy_end();
   endfunction

   function automatic bit exp_clr(input longint c);
      return r_on && c == r_t + 1;
   endfunction

   function automatic bit exp_en(input longint c);
      return r_on && c >= r_t + 2 && c <= last_push() && c <= r_stop;
   endfunction

   function automatic bit exp_strobe(input longint c);
      return exp_en(c) && ((c - r_t - 1) % r_D == 0);
   endfunction

   function automatic bit exp_push(input longint c);
      return r_on && c >= r_t + 2 + 4 * r_D && c <= last_push() && c < r_stop
             && ((c - r_t - 2) % r_D == 0);
   endfunction

   function automatic bit exp_done(input longint c);
      return r_on && r_n != 0 && c == last_push() + 1 && r_stop > last_push();
   endfunction

   // Mid-cycle check, then advance the FIFO/overflow model across the coming edge.
   always @(negedge clk) begin
      longint c;
      bit     pop, drop;
      c = cyc;
      if (!reset_n) begin
         check_val("rst_busy",     64'(busy),       64'(0));
         check_val("rst_cic_clr",  64'(cic_clr),    64'(0));
         check_val("rst_cic_en",   64'(cic_en),     64'(0));
         check_val("rst_strobe",   64'(dec_strobe), 64'(0));
         check_val("rst_done",     64'(done),       64'(0));
         check_val("rst_valid",    64'(out_valid),  64'(0));
         check_val("rst_data",     64'(out_data),   64'(0));
         check_val("rst_overflow", 64'(overflow),   64'(0));
         mq.delete();
         ovf_m    = 1'b0;
         pushed_m = 1'b0;
      end else begin
         check_val("busy",     64'(busy),       64'(exp_busy(c)));
         check_val("cic_clr",  64'(cic_clr),    64'(exp_clr(c)));
         check_val("cic_en",   64'(cic_en),     64'(exp_en(c)));
         check_val("strobe",   64'(dec_strobe), 64'(exp_strobe(c)));
         check_val("done",     64'(done),       64'(exp_done(c)));
         check_val("valid",    64'(out_valid),  64'(mq.size() != 0));
         check_val("overflow", 64'(overflow),   64'(ovf_m));
         if (mq.size() != 0) check_val("out_data", 64'(out_data), 64'(mq[0]));
         else if (!pushed_m) check_val("data_idle", 64'(out_data), 64'(0));
         pop  = (mq.size() != 0) && out_ready;
         drop = 1'b0;
         if (pop) void'(mq.pop_front());
         if (exp_push(c)) begin
            pushed_m = 1'b1;
            if (mq.size() < FIFO_DEPTH) mq.push_back(data_of(c));
            else drop = 1'b1;
         end
         ovf_m = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_m);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      cic_data = data_of(cyc);
      start    = 1'b0;
      stop     = 1'b0;
      dec_sel  = 2'($urandom);
      num_conv = CNT_W'($urandom);
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom);
      endcase
      clr_ovf = clr_rand ? ($urandom_range(0, 15) == 0) : 1'b0;
   endtask

   task automatic do_start(input logic [1:0] sel, input int n);
      dec_sel  = sel;
      num_conv = CNT_W'(n);
      start    = 1'b1;
      if (!stop && !exp_busy(cyc)) begin
         r_on   = 1'b1;
         r_t    = cyc;
         r_D    = (sel == 2'b00) ? 8 : (sel == 2'b01) ? 64 : 256;
         r_n    = n;
         r_stop = INF;
      end
   endtask

   task automatic do_stop();
      stop = 1'b1;
      if (exp_busy(cyc) && cyc < r_stop) r_stop = cyc;
   endtask

   task automatic run_until(input longint target);
      while (cyc < target) step();
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (exp_busy(cyc) && k < 20000) begin
         step();
         k++;
      end
      check_val("wait_idle", 64'(busy), 64'(exp_busy(cyc)));
   endtask

   task automatic apply_reset(input int cycles);
      reset_n = 1'b0;
      r_on    = 1'b0;
      repeat (cycles) step();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      dec_sel   = '0;
      num_conv  = '0;
      cic_data  = '0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      salt      = {$urandom, $urandom};
      repeat (3) step();
      reset_n = 1'b1;
      repeat (4) step();

      // ratio 8, five conversions, consumer always ready
      rdy_mode = 1;
      step(); do_start(2'b00, 5);
      wait_idle();
      repeat (4) step();

      // ratio 256 continuous; stop lands on the capture slot of strobe 7
      rdy_mode = 2;
      step(); do_start(2'b10, 0);
      run_until(r_t + 2 + 7 * 256);
      do_stop();
      wait_idle();
      rdy_mode = 1;
      repeat (8) step();

      // consumer stalled: 4 stored, 5th and 6th dropped, then drain and clear
      rdy_mode = 0;
      step(); do_start(2'b00, 6);
      wait_idle();
      repeat (3) step();
      rdy_mode = 1;
      repeat (8) step();
      step(); clr_ovf = 1'b1;
      repeat (2) step();

      // full FIFO: push with pop accepted; later drop coincides with clr_ovf
      rdy_mode = 0;
      step(); do_start(2'b00, 6);
      run_until(r_t + 2 + 8 * 8);
      out_ready = 1'b1;
      run_until(r_t + 2 + 9 * 8);
      clr_ovf = 1'b1;
      wait_idle();
      repeat (2) step();
      rdy_mode = 1;
      repeat (8) step();
      step(); clr_ovf = 1'b1;
      step();

      // start+stop together stays idle; start while busy is ignored
      step(); do_stop(); do_start(2'b00, 3);
      repeat (4) step();
      step(); do_start(2'b00, 3);
      repeat (5) step();
      do_start(2'b10, 1);
      wait_idle();
      repeat (3) step();

      // random runs with random stops, readiness and overflow clears
      rdy_mode = 2;
      clr_rand = 1'b1;
      for (int i = 0; i < 8; i++) begin
         int lim;
         step();
         do_start(2'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
         lim = int'($urandom_range(1, 500));
         for (int k = 0; k < lim && exp_busy(cyc); k++) step();
         if (exp_busy(cyc)) do_stop();
         wait_idle();
         repeat ($urandom_range(1, 5)) step();
      end
      clr_rand = 1'b0;

      // reset in the middle of a run with words queued, then a fresh run
      rdy_mode = 1;
      repeat (6) step();
      rdy_mode = 0;
      step(); do_start(2'b00, 0);
      run_until(r_t + 2 + 5 * 8 + 3);
      apply_reset(2);
      step();
      rdy_mode = 1;
      step(); do_start(2'b00, 2);
      wait_idle();
      repeat (6) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
